// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Bundles the keypad matrix pins and the decoded key outputs of the
//   keypad scanner.
//
//   Signals:
//     col_n       column returns from the matrix, active-low
//     row_n       row drive to the matrix, active-low, one bit low at a time
//     key_code    code of the last accepted key (row*4 + col)
//     key_valid   one-cycle pulse when a new key is accepted
//     key_held    high while the accepted key stays pressed
//     key_release one-cycle pulse when the held key is released
//     state_dbg   scanner state (0 = idle, 1 = key pressed)
//
//   Handshake: there is no back-pressure. key_valid and key_release are
//   single-cycle strobes that the consumer must sample on the cycle they
//   are high; key_code is stable from the key_valid cycle onwards until
//   the next key_valid.
//
//   Modports:
//     master  the scanner (drives rows and key outputs)
//     slave   the consumer / board side (drives columns)
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_release;
    logic       state_dbg;

    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_held,
        output key_release,
        output state_dbg
    );

    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  key_release,
        input  state_dbg
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Time-division scanner for a 4x4 active-low matrix keypad. Rows are
//   driven low one at a time for SCAN_DIV cycles each; the synchronized
//   column returns are latched at the end of each row slot into a 16-bit
//   frame snapshot. Each completed frame is classified as no key, a single
//   key or several keys, debounced over DEBOUNCE_FRAMES identical frames,
//   and turned into press / release events.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     kp     keypad_scanner_if.master (col_n in; row_n, key_code,
//            key_valid, key_held, key_release, state_dbg out)
module keypad_scanner #(
    parameter int SCAN_DIV        = 25000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX = 4'(DEBOUNCE_FRAMES);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESSED = 1'b1
    } state_t;

    // Registers
    logic [3:0]       col_s1_q, col_s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_n_q, row_n_d;
    logic [15:0]      snap_q, snap_d;
    logic [4:0]       cand_q, cand_d;     // {is_single, code}; NONE is 5'b0
    logic [3:0]       stab_q, stab_d;
    state_t           state_q, state_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             key_release_q, key_release_d;

    // Frame evaluation
    logic        tick;
    logic        frame_end;
    logic [3:0]  col_pressed;
    logic [15:0] frame_snap;
    logic [4:0]  pop;
    logic [3:0]  idx;
    logic        cls_multi;
    logic [4:0]  cls;
    logic        accept;

    assign tick        = (cnt_q == CNT_MAX);
    assign frame_end   = tick && (row_idx_q == 2'd3);
    assign col_pressed = ~col_s2_q;

    // Snapshot as it will look once the current row slot is latched, so the
    // frame-end classification sees all four rows including row 3.
    always_comb begin
        frame_snap = snap_q;
        case (row_idx_q)
            2'd0:    frame_snap[3:0]   = col_pressed;
            2'd1:    frame_snap[7:4]   = col_pressed;
            2'd2:    frame_snap[11:8]  = col_pressed;
            default: frame_snap[15:12] = col_pressed;
        endcase
    end

    always_comb begin
        pop = 5'd0;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + 5'(frame_snap[i]);
            if (frame_snap[i]) idx = 4'(i);
        end
    end

    assign cls_multi = (pop > 5'd1);
    // Code field forced to 0 for NONE so candidates compare as whole words.
    assign cls = (pop == 5'd1) ? {1'b1, idx} : 5'd0;

    // Scan, sample and debounce datapath
    always_comb begin
        cnt_d     = cnt_q;
        row_idx_d = row_idx_q;
        row_n_d   = row_n_q;
        snap_d    = snap_q;
        cand_d    = cand_q;
        stab_d    = stab_q;
        accept    = 1'b0;

        if (tick) begin
            cnt_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_n_d   = ~(4'b0001 << row_idx_d);
            snap_d    = frame_snap;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (frame_end) begin
            if (cls_multi) begin
                stab_d = 4'd0;
            end else if (cls == cand_q) begin
                if (stab_q < DEB_MAX) stab_d = stab_q + 4'd1;
            end else begin
                cand_d = cls;
                stab_d = 4'd1;
            end
            accept = !cls_multi && (stab_d == DEB_MAX);
        end
    end

    // Key state machine; acts only on an accepted frame.
    always_comb begin
        state_d       = state_q;
        key_code_d    = key_code_q;
        key_held_d    = key_held_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && cand_d[4]) begin
                    key_code_d  = cand_d[3:0];
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (accept) begin
                    if (!cand_d[4]) begin
                        key_held_d    = 1'b0;
                        key_release_d = 1'b1;
                        state_d       = S_IDLE;
                    end else if (cand_d[3:0] != key_code_q) begin
                        // Direct roll-over to another key: no release event.
                        key_code_d  = cand_d[3:0];
                        key_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q      <= 4'hF;
            col_s2_q      <= 4'hF;
            cnt_q         <= '0;
            row_idx_q     <= 2'd0;
            row_n_q       <= 4'b1110;
            snap_q        <= 16'd0;
            cand_q        <= 5'd0;
            stab_q        <= 4'd0;
            state_q       <= S_IDLE;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            col_s1_q      <= kp.col_n;
            col_s2_q      <= col_s1_q;
            cnt_q         <= cnt_d;
            row_idx_q     <= row_idx_d;
            row_n_q       <= row_n_d;
            snap_q        <= snap_d;
            cand_q        <= cand_d;
            stab_q        <= stab_d;
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
            key_release_q <= key_release_d;
        end
    end

    assign kp.row_n       = row_n_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_held    = key_held_q;
    assign kp.key_release = key_release_q;
    assign kp.state_dbg   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int DF = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] keys = 16'd0;
    logic [3:0]  col_drv;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_release = 0;

    // Frame-level reference model
    int         m_cand;   // -1 = no key, 0..15 = single key
    int         m_cnt;
    logic       m_held;
    logic [3:0] m_code;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp.master)
    );

    // Clock
    always #5 clk = ~clk;

    // Physical keypad: a column reads low when a pressed key sits on a
    // row that is currently driven low.
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.row_n[r] && keys[r*4+c]) col_drv[c] = 1'b0;
    end
    assign kp.col_n = col_drv;

    task automatic model_reset();
        m_cand = -1;
        m_cnt  = 0;
        m_held = 1'b0;
        m_code = 4'd0;
    endtask

    // Apply one whole frame of key state k to the model; report pulses.
    task automatic model_frame(input logic [15:0] k, output logic v, output logic rl);
        int n;
        int cls;
        v  = 1'b0;
        rl = 1'b0;
        n  = $countones(k);
        cls = -1;
        for (int i = 0; i < 16; i++) if (k[i]) cls = i;
        if (n >= 2) begin
            m_cnt = 0;
        end else begin
            if (cls == m_cand) m_cnt = (m_cnt + 1 > DF) ? DF : m_cnt + 1;
            else begin
                m_cand = cls;
                m_cnt  = 1;
            end
            if (m_cnt == DF) begin
                if (m_cand == -1 && m_held) begin
                    m_held = 1'b0;
                    rl = 1'b1;
                end else if (m_cand != -1 && (!m_held || m_cand != int'(m_code))) begin
                    m_held = 1'b1;
                    m_code = 4'(m_cand);
                    v = 1'b1;
                end
            end
        end
    endtask

    // Drive one frame of keys (called at the negedge after a frame end)
    // and check every output on every cycle of that frame.
    task automatic run_frame(input logic [15:0] k);
        logic v, rl, exp_v, exp_rl;
        logic [3:0] one;
        logic [3:0] exp_row;
        one  = 4'b0001;
        keys = k;
        model_frame(k, v, rl);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_row = ~(one << ((i / 4) % 4));
            exp_v   = (i == 16) ? v : 1'b0;
            exp_rl  = (i == 16) ? rl : 1'b0;
            if (kp.key_valid === 1'b1) n_valid++;
            if (kp.key_release === 1'b1) n_release++;
            checks++;
            if (kp.row_n !== exp_row) begin
                errors++;
                $display("FAIL row_n cyc %0d got %b want %b", i, kp.row_n, exp_row);
            end
            checks++;
            if (kp.key_valid !== exp_v || kp.key_release !== exp_rl) begin
                errors++;
                $display("FAIL pulses cyc %0d got v=%b r=%b want v=%b r=%b",
                         i, kp.key_valid, kp.key_release, exp_v, exp_rl);
            end
            // Model's held/code updates become visible at the frame end edge.
            if (i == 16) begin
                checks++;
                if (kp.key_held !== m_held || kp.key_code !== m_code || kp.state_dbg !== m_held) begin
                    errors++;
                    $display("FAIL held_code got h=%b c=%0d s=%b want h=%b c=%0d",
                             kp.key_held, kp.key_code, kp.state_dbg, m_held, m_code);
                end
            end
        end
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        for (int f = 0; f < n; f++) run_frame(k);
    endtask

    task automatic check_counts(input string name, input int dv, input int dr,
                                input int want_v, input int want_r);
        checks++;
        if (dv !== want_v || dr !== want_r) begin
            errors++;
            $display("FAIL %s got valid=%0d release=%0d want valid=%0d release=%0d",
                     name, dv, dr, want_v, want_r);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        keys  = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (kp.row_n !== 4'b1110 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 ||
            kp.key_held !== 1'b0 || kp.key_release !== 1'b0) begin
            errors++;
            $display("FAIL reset got row=%b code=%0d v=%b h=%b r=%b want 1110 0 0 0 0",
                     kp.row_n, kp.key_code, kp.key_valid, kp.key_held, kp.key_release);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int v0 = n_valid, r0 = n_release;
        run_frames(16'd0, 2);
        check_counts("idle", n_valid - v0, n_release - r0, 0, 0);
    endtask

    task automatic test_press_release();
        int v0 = n_valid, r0 = n_release;
        run_frames(16'h0200, 2);
        check_counts("key9_early", n_valid - v0, n_release - r0, 0, 0);
        run_frames(16'h0200, 3);
        check_counts("key9_accept", n_valid - v0, n_release - r0, 1, 0);
        checks++;
        if (kp.key_code !== 4'd9 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL key9_code got c=%0d h=%b want c=9 h=1", kp.key_code, kp.key_held);
        end
        run_frames(16'd0, 3);
        check_counts("key9_release", n_valid - v0, n_release - r0, 1, 1);
        checks++;
        if (kp.key_code !== 4'd9 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL key9_after got c=%0d h=%b want c=9 h=0", kp.key_code, kp.key_held);
        end
    endtask

    task automatic test_bounce();
        int v0 = n_valid, r0 = n_release;
        run_frame(16'd0);
        run_frame(16'h0020);
        run_frame(16'd0);
        run_frame(16'h0020);
        run_frame(16'd0);
        run_frames(16'h0020, 2);
        check_counts("bounce_quiet", n_valid - v0, n_release - r0, 0, 0);
        run_frame(16'h0020);
        check_counts("bounce_accept", n_valid - v0, n_release - r0, 1, 0);
        checks++;
        if (kp.key_code !== 4'd5) begin
            errors++;
            $display("FAIL bounce_code got %0d want 5", kp.key_code);
        end
    endtask

    task automatic test_multi();
        int v0, r0;
        run_frames(16'd0, 4);
        v0 = n_valid;
        r0 = n_release;
        run_frames(16'h8001, 6);
        check_counts("multi_ignored", n_valid - v0, n_release - r0, 0, 0);
        checks++;
        if (kp.key_held !== 1'b0 || kp.key_code !== 4'd5) begin
            errors++;
            $display("FAIL multi_state got h=%b c=%0d want h=0 c=5", kp.key_held, kp.key_code);
        end
        run_frames(16'h0001, 3);
        check_counts("multi_then_0", n_valid - v0, n_release - r0, 1, 0);
        checks++;
        if (kp.key_code !== 4'd0 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL key0_code got c=%0d h=%b want c=0 h=1", kp.key_code, kp.key_held);
        end
    endtask

    task automatic test_back_to_back();
        int v0, r0;
        run_frames(16'd0, 4);
        v0 = n_valid;
        r0 = n_release;
        run_frames(16'h0008, 3);
        run_frames(16'h1000, 3);
        check_counts("rollover", n_valid - v0, n_release - r0, 2, 0);
        checks++;
        if (kp.key_code !== 4'd12 || kp.key_held !== 1'b1) begin
            errors++;
            $display("FAIL rollover_code got c=%0d h=%b want c=12 h=1", kp.key_code, kp.key_held);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        run_frames(16'd0, 4);
        run_frames(16'h0080, 3);
        keys = 16'h0080;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (kp.row_n !== 4'b1110 || kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 ||
            kp.key_held !== 1'b0 || kp.key_release !== 1'b0) begin
            errors++;
            $display("FAIL midreset got row=%b code=%0d v=%b h=%b r=%b want 1110 0 0 0 0",
                     kp.row_n, kp.key_code, kp.key_valid, kp.key_held, kp.key_release);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        v0 = n_valid;
        run_frames(16'h0080, 2);
        check_counts("postreset_early", n_valid - v0, 0, 0, 0);
        run_frame(16'h0080);
        check_counts("postreset_accept", n_valid - v0, 0, 1, 0);
        checks++;
        if (kp.key_code !== 4'd7) begin
            errors++;
            $display("FAIL postreset_code got %0d want 7", kp.key_code);
        end
    endtask

    task automatic test_random();
        logic [15:0] k;
        int a, b;
        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 3))
                0: k = 16'd0;
                1, 2: k = 16'd1 << $urandom_range(0, 15);
                default: begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    k = (16'd1 << a) | (16'd1 << b);
                end
            endcase
            run_frames(k, $urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press_release();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the score display's time-division scan. Drives the rows of a 4x4 matrix keypad one at a time and samples the column returns.
- Debounces the result over whole scan frames and emits a one-hot-free key code with press/release pulses.
- Feeds the game control logic (direction, start, pause) in the same clock domain as the display.

Parameters:
- SCAN_DIV, 25000, clock cycles per row slot (4 slots = 1 frame); legal range >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical frames required to accept a state change; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- col_n  input  4  column returns, active-low (pull-ups on board), asynchronous to clk
- row_n  output  4  row drive, active-low, exactly one bit low at any time
- key_code  output  4  code of last accepted key = row_idx*4 + col_idx
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_held  output  1  high while an accepted key remains pressed
- key_release  output  1  one-cycle pulse when the held key is released

Behaviour:
- Reset is asynchronous, active-low, and may occur at any cycle. It returns every register to its reset value immediately; no partial frame survives.
- Reset values: row_n=4'b1110, key_code=0, key_valid=0, key_held=0, key_release=0, scan counter=0, row_idx=0, stability counter=0, state=S_IDLE.
- col_n passes through a 2-flop synchronizer before any use.
- Scan timing:
  - Counter runs 0..SCAN_DIV-1. tick asserts on the cycle the counter equals SCAN_DIV-1; the counter then wraps to 0.
  - On tick, row_idx increments mod 4, and row_n = ~(4'b0001 << row_idx) is registered.
- Sampling:
  - On tick, the synchronized columns for the current row (before the advance) are latched into bits [4*row_idx+3 : 4*row_idx] of a 16-bit frame snapshot; bit set = key pressed.
  - Sampling at slot end guarantees SCAN_DIV-3 cycles of settle time after the row change.
- Frame end is the tick with row_idx==3. The snapshot is classified as:
  - NONE: all zero.
  - SINGLE(k): exactly one bit set; k = its index.
  - MULTI: two or more bits set.
- Debounce:
  - MULTI frame: discarded. Stability counter cleared, candidate unchanged, outputs unchanged.
  - Otherwise, if the classification equals the candidate, the stability counter increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise, the candidate becomes the classification and the counter is set to 1.
  - Acceptance occurs at the frame end where the counter reaches DEBOUNCE_FRAMES and the candidate differs from the accepted state.
- State machine (evaluated on acceptance only):
  - S_IDLE, accept SINGLE(k): key_code<=k, key_valid pulse, key_held<=1, go to S_PRESSED.
  - S_PRESSED, accept NONE: key_held<=0, key_release pulse, key_code retained, go to S_IDLE.
  - S_PRESSED, accept SINGLE(j) with j!=key_code: key_code<=j, key_valid pulse, no release pulse, key_held stays 1.
  - Repeated acceptance of the current state produces no pulses and no auto-repeat.
- Latency: key_valid, key_release and the key_code update are registered outputs, asserted the cycle after the qualifying frame-end tick.
  - Minimum press-to-valid = DEBOUNCE_FRAMES frames after the first frame that captures the key, plus synchronizer delay.
- key_valid and key_release are never high in the same cycle. Each pulse is exactly one clk cycle wide.
- Counter widths: $clog2(SCAN_DIV) for the scan counter, 4 bits for the stability counter. No overflow is possible within legal parameter ranges.

Test Plan:
1. All benches use SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frame).
   - Reset, then run 32 cycles idle -> row_n cycles 1110,1101,1011,0111 changing every 4 cycles; all key outputs 0.
2. Hold row2/col1 low (key 9) steadily -> exactly one key_valid pulse with key_code=9 after the 3rd frame capturing it; key_held=1 thereafter. Release -> one key_release pulse after 3 clean frames; key_held=0; key_code stays 9.
3. Bounce key 5 (press/release alternating each frame) for 5 frames, then hold -> no pulses during the bounce; a single key_valid with code 5 only after 3 consecutive held frames.
4. Hold keys 0 and 15 together for 6 frames -> no outputs change. Then release key 15 -> key_valid with code 0 after 3 frames.
5. Hold key 3 until accepted, then switch directly to key 12 -> second key_valid with code 12; key_held stays 1 throughout; no key_release pulse.
6. Assert rst_n low mid-frame while key 7 is held and accepted -> outputs and row_n return to reset values in the same cycle. After release of reset with key 7 still held -> fresh key_valid (code 7) after 3 frames.
